// File: rtl/ksa_pkg.sv
// ksa_pkg: shared width default, generate/propagate pair type and stage-count helper for the Kogge-Stone adder
package ksa_pkg;
  localparam int KSA_WIDTH = 16;
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;
  function automatic int ksa_stages(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/ksa_black_cell.sv
// ksa_black_cell: prefix-tree node merging a high group with the adjacent lower group
import ksa_pkg::*;
module ksa_black_cell (
  input  gp_t hi,
  input  gp_t lo,
  output gp_t res
);
  assign res.g = hi.g | (hi.p & lo.g);
  assign res.p = hi.p & lo.p;
endmodule

// File: rtl/kogge_stone_adder_reg.sv
// kogge_stone_adder_reg: registered WIDTH-bit Kogge-Stone adder with carry-in/out, 1-cycle latency
// Optional signed-overflow output ovf when KSA_OVF_EN is defined.
import ksa_pkg::*;
module kogge_stone_adder_reg #(
  parameter int WIDTH = KSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef KSA_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int S = ksa_stages(WIDTH);
  gp_t             tree [0:S][0:WIDTH-1];
  gp_t             bit0;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_next;
  logic            cout_next;
  assign p = A ^ B;
  // cin is the position -1 group (g=cin, p=0); merging it into bit 0 up front keeps the tree at log2(WIDTH) stages
  ksa_black_cell u_cin (.hi('{g: A[0] & B[0], p: p[0]}), .lo('{g: cin, p: 1'b0}), .res(bit0));
  assign tree[0][0] = bit0;
  for (genvar i = 1; i < WIDTH; i++) begin : g_pre
    assign tree[0][i] = '{g: A[i] & B[i], p: p[i]};
  end
  for (genvar k = 0; k < S; k++) begin : g_stage
    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      if (i >= (1 << k)) begin : g_black
        ksa_black_cell u_bc (.hi(tree[k][i]), .lo(tree[k][i-(1<<k)]), .res(tree[k+1][i]));
      end else begin : g_pass
        assign tree[k+1][i] = tree[k][i];
      end
    end
  end
  assign carry[0] = cin;
  for (genvar i = 1; i < WIDTH; i++) begin : g_carry
    assign carry[i] = tree[S][i-1].g;
  end
  assign sum_next  = p ^ carry;
  assign cout_next = tree[S][WIDTH-1].g;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef KSA_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_next;
        cout <= cout_next;
`ifdef KSA_OVF_EN
        ovf  <= carry[WIDTH-1] ^ cout_next;
`endif
      end
    end
  end
endmodule

// File: tb/tb_kogge_stone_adder_reg.sv
// tb_kogge_stone_adder_reg: directed self-checking bench for the registered Kogge-Stone adder
// Covers the KSA_OVF_EN ovf output when that macro is defined.
module tb_kogge_stone_adder_reg;
  logic        clk = 0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic [15:0] sum;
  logic        cout;
  int          n_tests = 0;
  int          n_fail = 0;
`ifdef KSA_OVF_EN
  logic        ovf;
`endif

  kogge_stone_adder_reg #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b), .cin(cin),
`ifdef KSA_OVF_EN
    .ovf(ovf),
`endif
    .out_valid(out_valid), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] x, input logic [15:0] y, input logic c);
    @(negedge clk);
    rst = r; in_valid = v; a = x; b = y; cin = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input string tag, input logic [15:0] s, input logic co);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_sum"}, {16'b0, sum}, {16'b0, s});
    check({tag, "_cout"}, {31'b0, cout}, {31'b0, co});
  endtask

  initial begin
    logic [16:0] ref_res;
    logic [15:0] ra, rb;
    logic        rc;
    rst = 1; in_valid = 1; a = 16'hFFFF; b = 16'hFFFF; cin = 1;
    drive(1, 1, 16'hFFFF, 16'hFFFF, 1'b1);
    drive(1, 1, 16'hFFFF, 16'hFFFF, 1'b1);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum", {16'b0, sum}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);

    drive(0, 1, 16'h1234, 16'h4321, 1'b0);
    expect_res("basic", 16'h5555, 1'b0);
    drive(0, 1, 16'hFFFF, 16'h0000, 1'b1);
    expect_res("ripple_cin", 16'h0000, 1'b1);
    drive(0, 1, 16'h0001, 16'h7FFF, 1'b0);
    expect_res("ripple_msb", 16'h8000, 1'b0);
    drive(0, 1, 16'hFFFF, 16'hFFFF, 1'b1);
    expect_res("max", 16'hFFFF, 1'b1);
    drive(0, 1, 16'h0000, 16'h0000, 1'b0);
    expect_res("zero", 16'h0000, 1'b0);

    ref_res = '0;
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      ref_res = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
      drive(0, 1, ra, rb, rc);
      expect_res($sformatf("stream%0d", i), ref_res[15:0], ref_res[16]);
    end

    drive(0, 0, 16'h1111, 16'h2222, 1'b1);
    check("hold_valid", {31'b0, out_valid}, 32'd0);
    check("hold_sum", {16'b0, sum}, {16'b0, ref_res[15:0]});
    check("hold_cout", {31'b0, cout}, {31'b0, ref_res[16]});
    drive(0, 0, 16'h3333, 16'h4444, 1'b0);
    check("hold2_sum", {16'b0, sum}, {16'b0, ref_res[15:0]});

    drive(0, 1, 16'hF000, 16'h1000, 1'b1);
    expect_res("pre_rst", 16'h0001, 1'b1);
    drive(1, 1, 16'h1234, 16'h4321, 1'b0);
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_sum", {16'b0, sum}, 32'd0);
    check("midrst_cout", {31'b0, cout}, 32'd0);
    drive(0, 1, 16'h00FF, 16'h0001, 1'b0);
    expect_res("post_rst", 16'h0100, 1'b0);

`ifdef KSA_OVF_EN
    drive(0, 1, 16'h7FFF, 16'h0001, 1'b0);
    expect_res("ovf_pos", 16'h8000, 1'b0);
    check("ovf_pos_ovf", {31'b0, ovf}, 32'd1);
    drive(0, 1, 16'h8000, 16'h8000, 1'b0);
    expect_res("ovf_neg", 16'h0000, 1'b1);
    check("ovf_neg_ovf", {31'b0, ovf}, 32'd1);
    drive(0, 1, 16'h0001, 16'h0001, 1'b0);
    expect_res("ovf_none", 16'h0002, 1'b0);
    check("ovf_none_ovf", {31'b0, ovf}, 32'd0);
    drive(0, 1, 16'h7FFF, 16'h0001, 1'b0);
    drive(0, 0, 16'h0001, 16'h0001, 1'b0);
    check("ovf_hold", {31'b0, ovf}, 32'd1);
    drive(1, 0, 16'h0000, 16'h0000, 1'b0);
    check("ovf_rst", {31'b0, ovf}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
